// File: rtl/cfg_i2c_pkg.sv
// rtl/cfg_i2c_pkg.sv - shared types and constants for the configuration I2C master
package cfg_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        ACK,
        STOP,
        DONE_ST
    } state_t;

    localparam int REC_W            = 48;
    localparam int IDX_LO           = 0;
    localparam int IDX_HI           = 6;
    localparam int SEL_BIT          = 7;
    localparam int PTR_LO           = 8;
    localparam int PTR_HI           = 15;
    localparam int VAL_LO           = 16;
    localparam int VAL_HI           = 47;
    localparam int BYTES_PER_REC    = 6;
    localparam int QUARTERS_PER_BIT = 4;

    // Address byte plus the record bytes, as shifted out on the bus.
    localparam int FRAME_BITS = (BYTES_PER_REC + 1) * 8;

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - SCL quarter-period tick divider with synchronous clear
module i2c_qtick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Count up while enabled, wrapping on each tick; clear wins so a new frame starts on a full quarter.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 16'd1;
        end
    end

    // Divider register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cfg_i2c_master.sv
// rtl/cfg_i2c_master.sv - write-only I2C master sending one configuration record per frame
module cfg_i2c_master
    import cfg_i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [6:0]  SLAVE_ADDR = 7'h42
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [0:47]    REC,
    input  logic           REC_VALID,
    output logic           REC_READY,
    output logic           BUSY,
    output logic           DONE,
    output logic           NACK_ERR,
    output logic           SCL,
    inout  wire            SDA
);

    state_t                state_q, state_d;
    logic [1:0]            qtr_q, qtr_d;
    logic [2:0]            bit_q, bit_d;
    logic [2:0]            byte_q, byte_d;
    logic [0:REC_W-1]      rec_q, rec_d;
    logic                  nack_q, nack_d;
    logic                  done_q, nack_err_q;
    logic                  scl_q, scl_d;
    logic                  sda_low_q, sda_low_d;
    logic                  accept;
    logic                  on_bus;
    logic                  tick;
    logic                  qtr_last;
    logic [0:FRAME_BITS-1] frame_d;
    logic [5:0]            bit_idx_d;

    // DONE is registered one cycle after DONE_ST, so READY is held off through the DONE cycle.
    assign REC_READY = (state_q == IDLE) && !done_q;
    assign BUSY      = (state_q != IDLE) || done_q;
    assign DONE      = done_q;
    assign NACK_ERR  = nack_err_q;
    assign SCL       = scl_q;
    assign SDA       = sda_low_q ? 1'b0 : 1'bz;

    assign accept    = REC_VALID && REC_READY;
    assign on_bus    = (state_q == START) || (state_q == SHIFT) ||
                       (state_q == ACK)   || (state_q == STOP);
    assign qtr_last  = (qtr_q == 2'(QUARTERS_PER_BIT - 1));

    i2c_qtick #(
        .DIV (CLK_DIV)
    ) u_qtick (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .clr_i   (accept),
        .en_i    (on_bus),
        .tick_o  (tick)
    );

    // Next-state: frame sequencing advances only on quarter ticks; ACK/NACK is sampled at the end of ACK Q2.
    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        rec_d   = rec_q;
        nack_d  = nack_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    qtr_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    rec_d   = REC;
                    nack_d  = 1'b0;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if ((state_q == ACK) && (qtr_q == 2'd2)) begin
                        nack_d = SDA;
                    end
                    if (qtr_last) begin
                        case (state_q)
                            START: begin
                                state_d = SHIFT;
                                bit_d   = '0;
                            end
                            SHIFT: begin
                                if (bit_q == 3'd7) begin
                                    state_d = ACK;
                                end else begin
                                    bit_d = bit_q + 3'd1;
                                end
                            end
                            ACK: begin
                                if (nack_q || (byte_q == 3'(BYTES_PER_REC))) begin
                                    state_d = STOP;
                                end else begin
                                    state_d = SHIFT;
                                    bit_d   = '0;
                                    byte_d  = byte_q + 3'd1;
                                end
                            end
                            STOP:    state_d = DONE_ST;
                            default: state_d = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Bus levels decoded from the next state so SCL/SDA come straight from flops.
    always_comb begin
        frame_d   = {SLAVE_ADDR, 1'b0, rec_d};
        bit_idx_d = {byte_d, bit_d};
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state_d)
            START: begin
                scl_d     = (qtr_d < 2'd2);
                sda_low_d = (qtr_d != 2'd0);
            end
            SHIFT: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_low_d = !frame_d[bit_idx_d];
            end
            ACK: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_low_d = 1'b0;
            end
            STOP: begin
                scl_d     = (qtr_d != 2'd0);
                sda_low_d = (qtr_d < 2'd2);
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    // State register; reset releases the bus immediately without a STOP.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            qtr_q      <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            rec_q      <= '0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            rec_q      <= rec_d;
            nack_q     <= nack_d;
            done_q     <= (state_q == DONE_ST);
            nack_err_q <= (state_q == DONE_ST) && nack_q;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
        end
    end

endmodule

// File: tb/tb_cfg_i2c_master.sv
// tb/tb_cfg_i2c_master.sv - self-checking bench for cfg_i2c_master with a bus-level slave model
module tb_cfg_i2c_master;

    localparam int         D    = 2;
    localparam logic [6:0] ADDR = 7'h42;
    localparam logic [5:0] IDLE_V = 6'b110001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:47] rec = '0;
    logic        rec_valid = 1'b0;
    logic        rec_ready, busy, done, nack_err, scl;
    wire         sda_w;
    bit          s_drive;

    pullup (sda_w);
    assign sda_w = s_drive ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    cfg_i2c_master #(
        .CLK_DIV    (D),
        .SLAVE_ADDR (ADDR)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REC       (rec),
        .REC_VALID (rec_valid),
        .REC_READY (rec_ready),
        .BUSY      (busy),
        .DONE      (done),
        .NACK_ERR  (nack_err),
        .SCL       (scl),
        .SDA       (sda_w)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_edge = 0;
    int done_cyc = 0;
    int last_lat = 0;
    int nack_byte = 7;

    // Expected {scl, sda, busy, done, nack_err, ready} per cycle; empty queue means bus idle.
    logic [5:0] exp_q[$];
    logic [7:0] obs_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Slave: START resets it; it pulls SDA low from the 8th SCL fall to the 9th unless told to NACK this byte.
    int         s_bits = 0;
    int         s_byte = 0;
    logic [7:0] s_shift = '0;

    always @(negedge sda_w) begin
        if (scl === 1'b1) begin
            s_bits = 0;
            s_byte = 0;
        end
    end

    always @(posedge scl) begin
        if (s_bits < 8) s_shift = {s_shift[6:0], sda_w};
        s_bits++;
        if (s_bits == 8) obs_b.push_back(s_shift);
    end

    always @(negedge scl) begin
        if (s_bits == 8 && s_byte != nack_byte) begin
            s_drive = 1'b1;
        end else if (s_bits >= 9) begin
            s_drive = 1'b0;
            s_bits  = 0;
            s_byte++;
        end
    end

    // Model: builds the whole frame as a list of quarter-period bus levels, then expands it to cycles.
    task automatic push_frame(input logic [0:47] r, input int nk);
        logic [1:0] qv[$];
        logic [7:0] b;
        bit         ack;
        bit         aborted;
        aborted = 1'b0;
        qv.push_back(2'b11); qv.push_back(2'b10); qv.push_back(2'b00); qv.push_back(2'b00);
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) b = {ADDR, 1'b0};
            else        b = r[8*(k-1) +: 8];
            ack = (k != nk);
            for (int j = 7; j >= 0; j--) begin
                qv.push_back({1'b0, b[j]});
                qv.push_back({1'b1, b[j]});
                qv.push_back({1'b1, b[j]});
                qv.push_back({1'b0, (j == 0 && ack) ? 1'b0 : b[j]});
            end
            qv.push_back({1'b0, !ack});
            qv.push_back({1'b1, !ack});
            qv.push_back({1'b1, !ack});
            qv.push_back(2'b01);
            if (!ack) begin
                aborted = 1'b1;
                break;
            end
        end
        qv.push_back(2'b00); qv.push_back(2'b10); qv.push_back(2'b11); qv.push_back(2'b11);
        foreach (qv[i]) begin
            for (int c = 0; c < D; c++) exp_q.push_back({qv[i], 4'b1000});
        end
        exp_q.push_back(6'b111000);
        exp_q.push_back({4'b1111, aborted, 1'b0});
    endtask

    // Compare DUT outputs against the model on every cycle, away from the active edge.
    always @(negedge clk) begin : cmp
        logic [5:0] e;
        logic [5:0] a;
        cyc++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
        a = {scl, sda_w, busy, done, nack_err, rec_ready};
        check($sformatf("cycle%0d scl_sda_busy_done_nack_ready", cyc), {58'd0, a}, {58'd0, e});
        if (done) begin
            done_cyc = cyc;
            last_lat = cyc - acc_edge;
        end
    end

    task automatic send(input logic [0:47] r, input int nk, input bit hold);
        bit rd;
        bit acc;
        acc       = 1'b0;
        nack_byte = nk;
        rec       = r;
        rec_valid = 1'b1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            rd = rec_ready;
            @(posedge clk);
            if (rd) begin
                acc      = 1'b1;
                acc_edge = cyc + 1;
                push_frame(r, nk);
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual no acceptance required acceptance within 2000 cycles");
        end
        #1;
        if (!hold) rec_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            #1;
            idle = (exp_q.size() == 0);
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout actual frame still pending required frame end within 3000 cycles");
        end
    endtask

    logic [7:0] norm_b [7] = '{8'h84, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    logic [7:0] nak_b  [4] = '{8'h84, 8'h12, 8'h34, 8'h56};
    int         d1_done;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl",   scl,       1);
        check("rst_sda",   sda_w,     1);
        check("rst_ready", rec_ready, 1);
        check("rst_busy",  busy,      0);
        check("rst_done",  done,      0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Normal frame, every byte acknowledged.
        obs_b.delete();
        send(48'h05_00_00_00_00_03, 7, 1'b0);
        wait_idle();
        check("norm_done_latency", last_lat, 521);
        check("norm_byte_count", obs_b.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < obs_b.size()) check($sformatf("norm_byte%0d", i), obs_b[i], norm_b[i]);
        end

        // NACK on the third data byte.
        obs_b.delete();
        send(48'h12_34_56_78_9A_BC, 3, 1'b0);
        wait_idle();
        check("dnak_done_latency", last_lat, 305);
        check("dnak_byte_count", obs_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_b.size()) check($sformatf("dnak_byte%0d", i), obs_b[i], nak_b[i]);
        end

        // Address NACK.
        obs_b.delete();
        send(48'hFF_EE_DD_CC_BB_AA, 0, 1'b0);
        wait_idle();
        check("anak_done_latency", last_lat, 89);
        check("anak_byte_count", obs_b.size(), 1);
        if (obs_b.size() > 0) check("anak_byte0", obs_b[0], 8'h84);

        // Back-to-back records with REC_VALID held.
        obs_b.delete();
        send(48'hA5_5A_C3_3C_0F_F0, 7, 1'b1);
        send(48'h01_23_45_67_89_AB, 7, 1'b0);
        d1_done = done_cyc;
        check("b2b_accept_gap", acc_edge - d1_done, 2);
        wait_idle();
        check("b2b_done_latency", last_lat, 521);
        check("b2b_byte_count", obs_b.size(), 14);
        if (obs_b.size() == 14) begin
            check("b2b_f1_byte1", obs_b[1],  8'hA5);
            check("b2b_f1_byte6", obs_b[6],  8'hF0);
            check("b2b_f2_addr",  obs_b[7],  8'h84);
            check("b2b_f2_byte6", obs_b[13], 8'hAB);
        end

        // Reset in the middle of data byte 4, then a full frame.
        send(48'h11_22_33_44_55_66, 7, 1'b0);
        repeat (162 * D) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_scl",  scl,       1);
        check("mrst_sda",  sda_w,     1);
        check("mrst_busy", busy,      0);
        check("mrst_ready", rec_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        obs_b.delete();
        send(48'h05_00_00_00_00_03, 7, 1'b0);
        wait_idle();
        check("mrst_done_latency", last_lat, 521);
        check("mrst_byte_count", obs_b.size(), 7);
        if (obs_b.size() == 7) begin
            check("mrst_byte0", obs_b[0], 8'h84);
            check("mrst_byte6", obs_b[6], 8'h03);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
